gcm_gctr_sequencer: RTL and testbench

//  Packet-level controller for the gctr_block AES/GCTR core. Per packet it sequences the core through:

---
 rtl/gcm_gctr_sequencer_if.sv | 79 +++++++
 rtl/gcm_gctr_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_gcm_gctr_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcm_gctr_sequencer_if.sv
// Bundle of every non-clock signal of the GCTR packet sequencer.
//   slave  : the sequencer's view (framer stream in, result stream out,
//            H / E(K,Y0) to the tag stage, request/result with gctr_block)
//   master : the surrounding logic's view (framer, downstream, core)
// Signal suffixes are from the sequencer's point of view.
interface gcm_gctr_sequencer_if #(
  parameter int CNT_W = 16
);
  // packet configuration from the framer
  logic             start_i;
  logic             encdec_i;
  logic             keylen_i;
  logic [255:0]     key_i;
  logic [95:0]      iv_i;
  logic             empty_i;
  // payload stream in
  logic [127:0]     block_i;
  logic             block_valid_i;
  logic             block_last_i;
  logic             block_ready_o;
  // result stream out
  logic [127:0]     data_o;
  logic             data_valid_o;
  logic             data_ready_i;
  // to GHASH / tag stage
  logic [127:0]     hkey_o;
  logic             hkey_valid_o;
  logic [127:0]     eky0_o;
  logic             eky0_valid_o;
  // status
  logic [CNT_W-1:0] blk_count_o;
  logic             busy_o;
  logic             done_o;
  logic             error_o;
  // gctr_block request
  logic             core_init_o;
  logic             core_opmode_o;
  logic             core_encdec_o;
  logic [95:0]      core_iv_o;
  logic             core_iv_valid_o;
  logic [255:0]     core_key_o;
  logic             core_key_valid_o;
  logic             core_keylen_o;
  logic             core_y0_o;
  logic             core_hkey_o;
  logic [127:0]     core_block_o;
  logic             core_block_valid_o;
  // gctr_block result
  logic [127:0]     core_result_i;
  logic             core_result_valid_i;

  modport slave (
    input  start_i, encdec_i, keylen_i, key_i, iv_i, empty_i,
    input  block_i, block_valid_i, block_last_i,
    output block_ready_o,
    output data_o, data_valid_o,
    input  data_ready_i,
    output hkey_o, hkey_valid_o, eky0_o, eky0_valid_o,
    output blk_count_o, busy_o, done_o, error_o,
    output core_init_o, core_opmode_o, core_encdec_o, core_iv_o, core_iv_valid_o,
    output core_key_o, core_key_valid_o, core_keylen_o, core_y0_o, core_hkey_o,
    output core_block_o, core_block_valid_o,
    input  core_result_i, core_result_valid_i
  );

  modport master (
    output start_i, encdec_i, keylen_i, key_i, iv_i, empty_i,
    output block_i, block_valid_i, block_last_i,
    input  block_ready_o,
    input  data_o, data_valid_o,
    output data_ready_i,
    input  hkey_o, hkey_valid_o, eky0_o, eky0_valid_o,
    input  blk_count_o, busy_o, done_o, error_o,
    input  core_init_o, core_opmode_o, core_encdec_o, core_iv_o, core_iv_valid_o,
    input  core_key_o, core_key_valid_o, core_keylen_o, core_y0_o, core_hkey_o,
    input  core_block_o, core_block_valid_o,
    output core_result_i, core_result_valid_i
  );
endinterface

// File: rtl/gcm_gctr_sequencer.sv
// Packet-level controller for the gctr_block AES/GCTR core.
// Per packet: H = E(K,0^128), one GCTR op per 128-bit payload block,
// then E(K,Y0) for the tag. At most one payload block is in flight.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    gcm_gctr_sequencer_if.slave: framer config + payload stream in,
//          result stream out, H / E(K,Y0) pulses, status, gctr_block link
module gcm_gctr_sequencer #(
  parameter int MAX_BLOCKS = 16,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  gcm_gctr_sequencer_if.slave bus
);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HKEY, S_BLK_IN, S_BLK_RUN, S_BLK_OUT, S_Y0, S_DONE, S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic               encdec_q, encdec_d;
  logic               keylen_q, keylen_d;
  logic [255:0]       key_q, key_d;
  logic [95:0]        iv_q, iv_d;
  logic               empty_q, empty_d;
  logic [127:0]       blk_q, blk_d;
  logic               last_q, last_d;
  logic               ovf_q, ovf_d;
  logic [127:0]       data_q, data_d;
  logic               data_vld_q, data_vld_d;
  logic [127:0]       hkey_q, hkey_d;
  logic               hkey_vld_q, hkey_vld_d;
  logic [127:0]       eky0_q, eky0_d;
  logic               eky0_vld_q, eky0_vld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               rv_q;

  logic run_st, req, rise, tmo, idle_st;

  // A core op is outstanding in these three states.
  assign run_st  = (state_q == S_HKEY) || (state_q == S_BLK_RUN) || (state_q == S_Y0);
  assign idle_st = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
  // Gating on the registered valid keeps a new request off the bus until the
  // previous result has gone low, so its tail is never seen as a fresh edge.
  assign req     = run_st && !rv_q;
  assign rise    = run_st && bus.core_result_valid_i && !rv_q;
  assign tmo     = run_st && !rise && (tmr_q == TMR_W'(TIMEOUT));

  always_comb begin
    state_d    = state_q;
    encdec_d   = encdec_q;
    keylen_d   = keylen_q;
    key_d      = key_q;
    iv_d       = iv_q;
    empty_d    = empty_q;
    blk_d      = blk_q;
    last_d     = last_q;
    ovf_d      = ovf_q;
    data_d     = data_q;
    data_vld_d = data_vld_q;
    hkey_d     = hkey_q;
    hkey_vld_d = 1'b0;
    eky0_d     = eky0_q;
    eky0_vld_d = 1'b0;
    cnt_d      = cnt_q;
    // Timer restarts on every state change because non-run states and edges zero it.
    tmr_d      = (run_st && !rise) ? tmr_q + TMR_W'(1) : '0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start_i) begin
          encdec_d   = bus.encdec_i;
          keylen_d   = bus.keylen_i;
          key_d      = bus.key_i;
          iv_d       = bus.iv_i;
          empty_d    = bus.empty_i;
          cnt_d      = '0;
          ovf_d      = 1'b0;
          data_vld_d = 1'b0;
          state_d    = S_HKEY;
        end
      end
      S_HKEY: begin
        if (rise) begin
          hkey_d     = bus.core_result_i;
          hkey_vld_d = 1'b1;
          state_d    = empty_q ? S_Y0 : S_BLK_IN;
        end else if (tmo) begin
          state_d = S_ERROR;
        end
      end
      S_BLK_IN: begin
        if (bus.block_valid_i) begin
          blk_d   = bus.block_i;
          last_d  = bus.block_last_i;
          ovf_d   = (cnt_q == CNT_W'(MAX_BLOCKS)) && !bus.block_last_i;
          state_d = S_BLK_RUN;
        end
      end
      S_BLK_RUN: begin
        if (rise) begin
          data_d     = bus.core_result_i;
          data_vld_d = 1'b1;
          state_d    = S_BLK_OUT;
        end else if (tmo) begin
          state_d = S_ERROR;
        end
      end
      S_BLK_OUT: begin
        if (bus.data_ready_i) begin
          data_vld_d = 1'b0;
          cnt_d      = cnt_q + CNT_W'(1);
          // An over-long packet is flushed block by block, then halts.
          if (last_q)     state_d = S_Y0;
          else if (ovf_q) state_d = S_ERROR;
          else            state_d = S_BLK_IN;
        end
      end
      S_Y0: begin
        if (rise) begin
          eky0_d     = bus.core_result_i;
          eky0_vld_d = 1'b1;
          state_d    = S_DONE;
        end else if (tmo) begin
          state_d = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      encdec_q   <= 1'b0;
      keylen_q   <= 1'b0;
      key_q      <= '0;
      iv_q       <= '0;
      empty_q    <= 1'b0;
      blk_q      <= '0;
      last_q     <= 1'b0;
      ovf_q      <= 1'b0;
      data_q     <= '0;
      data_vld_q <= 1'b0;
      hkey_q     <= '0;
      hkey_vld_q <= 1'b0;
      eky0_q     <= '0;
      eky0_vld_q <= 1'b0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      rv_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      encdec_q   <= encdec_d;
      keylen_q   <= keylen_d;
      key_q      <= key_d;
      iv_q       <= iv_d;
      empty_q    <= empty_d;
      blk_q      <= blk_d;
      last_q     <= last_d;
      ovf_q      <= ovf_d;
      data_q     <= data_d;
      data_vld_q <= data_vld_d;
      hkey_q     <= hkey_d;
      hkey_vld_q <= hkey_vld_d;
      eky0_q     <= eky0_d;
      eky0_vld_q <= eky0_vld_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      rv_q       <= bus.core_result_valid_i;
    end
  end

  assign bus.block_ready_o      = (state_q == S_BLK_IN);
  assign bus.data_o             = data_q;
  assign bus.data_valid_o       = data_vld_q;
  assign bus.hkey_o             = hkey_q;
  assign bus.hkey_valid_o       = hkey_vld_q;
  assign bus.eky0_o             = eky0_q;
  assign bus.eky0_valid_o       = eky0_vld_q;
  assign bus.blk_count_o        = cnt_q;
  assign bus.busy_o             = !idle_st;
  assign bus.done_o             = (state_q == S_DONE);
  assign bus.error_o            = (state_q == S_ERROR);

  assign bus.core_init_o        = req;
  assign bus.core_opmode_o      = 1'b0;
  assign bus.core_encdec_o      = encdec_q;
  assign bus.core_iv_o          = iv_q;
  assign bus.core_iv_valid_o    = req;
  assign bus.core_key_o         = key_q;
  assign bus.core_key_valid_o   = req;
  assign bus.core_keylen_o      = keylen_q;
  assign bus.core_hkey_o        = req && (state_q == S_HKEY);
  assign bus.core_y0_o          = req && (state_q == S_Y0);
  assign bus.core_block_o       = blk_q;
  assign bus.core_block_valid_o = req && (state_q == S_BLK_RUN);
endmodule

// File: tb/tb_gcm_gctr_sequencer.sv
// Bench for gcm_gctr_sequencer. A behavioural stand-in for gctr_block
// answers requests with a simple keyed transform; a negedge monitor pops
// expected H / E(K,Y0) / data values from queues filled by the stimulus.
module tb_gcm_gctr_sequencer;
  localparam int T    = 255;
  localparam int MAXB = 2;   // small so an over-long packet is cheap to build

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcm_gctr_sequencer_if #(.CNT_W(16)) bus ();

  gcm_gctr_sequencer #(.MAX_BLOCKS(MAXB), .TIMEOUT(T), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic unexp(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s pulse with nothing expected", nm);
  endtask

  // Stand-in core transforms (stream op is an XOR, so encrypt/decrypt agree).
  function automatic logic [127:0] fH(input logic [255:0] k, input logic kl);
    return k[255:128] ^ k[127:0] ^ {127'b0, kl};
  endfunction
  function automatic logic [127:0] fE(input logic [255:0] k, input logic [95:0] iv);
    return {iv, 32'h1} ^ k[255:128];
  endfunction
  function automatic logic [127:0] fB(input logic [127:0] b, input logic [255:0] k,
                                      input logic [95:0] iv);
    return b ^ k[127:0] ^ k[255:128] ^ {iv, 32'h2};
  endfunction

  logic [127:0] exp_h[$];
  logic [127:0] exp_e[$];
  logic [127:0] exp_d[$];

  bit           cur_ed, cur_kl;
  logic [255:0] cur_key;

  // ---------------- core stand-in ----------------
  bit           stub_dead = 1'b0;
  int           stub_lat  = 3;
  bit           sbusy     = 1'b0;
  int           scnt      = 0;
  int           shold     = 0;
  logic [127:0] sres;

  always @(negedge clk) begin
    if (sbusy) begin
      if (scnt > 0) scnt <= scnt - 1;
      else if (shold == 0) begin
        bus.core_result_i       <= sres;
        bus.core_result_valid_i <= 1'b1;
        shold <= 1;
      end else if (shold == 1) begin
        // the sequencer saw the edge one posedge ago; its request must be gone
        shold <= 2;
        chk("core_req_dropped", bus.core_init_o, 1'b0);
      end else begin
        bus.core_result_valid_i <= 1'b0;
        sbusy <= 1'b0;
        shold <= 0;
      end
    end else if (rst) begin
      bus.core_result_valid_i <= 1'b0;
      bus.core_result_i       <= '0;
    end else if (!stub_dead && bus.core_init_o) begin
      sbusy <= 1'b1;
      scnt  <= stub_lat;
      chk("core_req_fields",
          {bus.core_key_valid_o, bus.core_iv_valid_o, bus.core_opmode_o,
           bus.core_encdec_o, bus.core_keylen_o},
          {1'b1, 1'b1, 1'b0, cur_ed, cur_kl});
      chk("core_key", bus.core_key_o, cur_key);
      if (bus.core_hkey_o)             sres <= fH(bus.core_key_o, bus.core_keylen_o);
      else if (bus.core_y0_o)          sres <= fE(bus.core_key_o, bus.core_iv_o);
      else if (bus.core_block_valid_o) sres <= fB(bus.core_block_o, bus.core_key_o, bus.core_iv_o);
      else                             sres <= '1;
    end
  end

  // ---------------- downstream ready ----------------
  int rdy_mode = 0;
  int stall_n  = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) bus.data_ready_i = 1'b1;
    else if (stall_n < 20) begin
      bus.data_ready_i = 1'b0;
      if (bus.data_valid_o) stall_n++;
    end else bus.data_ready_i = 1'($urandom_range(0, 1));
  end

  // ---------------- monitor ----------------
  bit seen_ready = 1'b0;
  always @(negedge clk) begin
    if (bus.block_ready_o) seen_ready = 1'b1;
    if (bus.data_valid_o) chk("ready_while_valid", bus.block_ready_o, 1'b0);
    if (bus.hkey_valid_o) begin
      if (exp_h.size() == 0) unexp("hkey");
      else chk("hkey", bus.hkey_o, exp_h.pop_front());
    end
    if (bus.eky0_valid_o) begin
      if (exp_e.size() == 0) unexp("eky0");
      else chk("eky0", bus.eky0_o, exp_e.pop_front());
    end
    if (bus.data_valid_o && !bus.data_ready_i && rdy_mode == 1 && exp_d.size() > 0)
      chk("data_stall_stable", {bus.block_ready_o, bus.data_o}, {1'b0, exp_d[0]});
    if (bus.data_valid_o && bus.data_ready_i) begin
      if (exp_d.size() == 0) unexp("data");
      else chk("data", bus.data_o, exp_d.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  logic [127:0] pt[3];
  logic [127:0] din[3];
  logic [127:0] dexp[3];
  logic [255:0] key1, key2;
  logic [95:0]  iv1;

  // all tasks start and end 1 time unit after a posedge
  task automatic start_pkt(input bit ed, input bit kl, input logic [255:0] k,
                           input logic [95:0] iv, input bit empty, input bit push_h,
                           input bit push_e);
    cur_ed = ed; cur_kl = kl; cur_key = k;
    bus.encdec_i = ed; bus.keylen_i = kl; bus.key_i = k; bus.iv_i = iv;
    bus.empty_i = empty; bus.start_i = 1'b1;
    if (push_h) exp_h.push_back(fH(k, kl));
    if (push_e) exp_e.push_back(fE(k, iv));
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    chk("start_status", {bus.busy_o, bus.done_o, bus.error_o}, 3'b100);
  endtask

  task automatic send_blk(input logic [127:0] b, input bit last, output bit ok);
    bus.block_i = b; bus.block_last_i = last; bus.block_valid_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.block_ready_o) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.block_valid_i = 1'b0;
    bus.block_last_i  = 1'b0;
  endtask

  task automatic run_pkt(input bit ed, input bit kl, input logic [255:0] k,
                         input logic [95:0] iv, input int n);
    bit ok;
    start_pkt(ed, kl, k, iv, n == 0, 1'b1, 1'b1);
    for (int i = 0; i < n; i++) begin
      exp_d.push_back(dexp[i]);
      send_blk(din[i], i == n - 1, ok);
      chk("blk_accepted", ok, 1'b1);
    end
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus.done_o) begin ok = 1'b1; break; end
    end
    chk("done_reached", ok, 1'b1);
    chk("blk_count", bus.blk_count_o, 16'(n));
    chk("done_status", {bus.busy_o, bus.error_o}, 2'b00);
    @(negedge clk);
    chk("queues_drained", exp_h.size() + exp_e.size() + exp_d.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin : main
    bit ok;
    int k;
    key1 = 256'hE3C08A8F06C6E3AD95A70557B23F75483CE33021A9C72B7025666204C69C0B72;
    key2 = {128'hAD7A2BD03EAC835A6F620FDCB506B345, 128'h0};
    iv1  = 96'h12153524C0895E81B2C28465;
    pt[0] = 128'h08000F101112131415161718191A1B1C;
    pt[1] = 128'h1D1E1F202122232425262728292A2B2C;
    pt[2] = 128'h2D2E2F303132333435363738393A0002;
    bus.start_i = 0; bus.encdec_i = 0; bus.keylen_i = 0; bus.key_i = '0;
    bus.iv_i = '0; bus.empty_i = 0; bus.block_i = '0; bus.block_valid_i = 0;
    bus.block_last_i = 0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_status", {bus.busy_o, bus.done_o, bus.error_o, bus.block_ready_o,
                       bus.data_valid_o, bus.hkey_valid_o, bus.eky0_valid_o,
                       bus.core_init_o, bus.core_block_valid_o}, 9'b0);
    chk("rst_count", bus.blk_count_o, 16'd0);
    chk("rst_key", bus.core_key_o, 256'd0);
    chk("rst_data", {bus.data_o, bus.hkey_o}, 256'd0);

    // 1: 256-bit encrypt, three blocks
    for (int i = 0; i < 3; i++) begin din[i] = pt[i]; dexp[i] = fB(pt[i], key1, iv1); end
    run_pkt(1'b1, 1'b1, key1, iv1, 3);
    // 2: decrypt of the test-1 results returns the plaintext
    for (int i = 0; i < 3; i++) begin din[i] = fB(pt[i], key1, iv1); dexp[i] = pt[i]; end
    run_pkt(1'b0, 1'b1, key1, iv1, 3);
    // 3: 128-bit key
    for (int i = 0; i < 3; i++) begin din[i] = pt[i]; dexp[i] = fB(pt[i], key2, iv1); end
    run_pkt(1'b1, 1'b0, key2, iv1, 3);
    // 4: empty packet, payload stream never opens
    seen_ready = 1'b0;
    run_pkt(1'b1, 1'b1, key1, iv1, 0);
    chk("empty_no_ready", seen_ready, 1'b0);

    // over-long packet: third non-last block exceeds MAXB, ERROR after its output
    start_pkt(1'b1, 1'b1, key1, iv1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_d.push_back(fB(pt[i], key1, iv1));
      send_blk(pt[i], 1'b0, ok);
      chk("ovf_blk_accepted", ok, 1'b1);
    end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.error_o) begin ok = 1'b1; break; end
    end
    chk("ovf_error", ok, 1'b1);
    chk("ovf_count", bus.blk_count_o, 16'd3);
    repeat (4) @(negedge clk);
    chk("ovf_stalled", {bus.busy_o, bus.block_ready_o, bus.error_o}, 3'b001);
    chk("ovf_drained", exp_h.size() + exp_e.size() + exp_d.size(), 0);
    @(posedge clk); #1;

    // 5: restart from ERROR, 20-cycle stall then random ready
    stall_n = 0; rdy_mode = 1;
    for (int i = 0; i < 3; i++) begin din[i] = pt[i]; dexp[i] = fB(pt[i], key1, iv1); end
    run_pkt(1'b1, 1'b1, key1, iv1, 3);
    rdy_mode = 0;
    chk("stall_cycles", stall_n, 20);

    // 6a: core never answers -> ERROR exactly TIMEOUT+1 cycles into HKEY
    stub_dead = 1'b1;
    start_pkt(1'b1, 1'b1, key1, iv1, 1'b0, 1'b0, 1'b0);
    k = 0;
    for (int i = 1; i <= T + 5; i++) begin
      @(posedge clk); #1;
      if (bus.error_o) begin k = i; break; end
    end
    chk("timeout_cycles", k, T + 1);
    chk("timeout_status", {bus.busy_o, bus.core_init_o, bus.core_hkey_o}, 3'b000);

    // 6b: reset while a block op is outstanding
    stub_dead = 1'b0; stub_lat = 10;
    start_pkt(1'b1, 1'b1, key1, iv1, 1'b0, 1'b1, 1'b0);
    send_blk(pt[0], 1'b1, ok);
    chk("rst_blk_accepted", ok, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("in_blk_run", bus.core_block_valid_o, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_status", {bus.busy_o, bus.done_o, bus.error_o, bus.block_ready_o,
                          bus.data_valid_o, bus.hkey_valid_o, bus.core_init_o,
                          bus.core_block_valid_o}, 8'b0);
    chk("midrst_regs", {bus.hkey_o, bus.data_o}, 256'd0);
    chk("midrst_count", bus.blk_count_o, 16'd0);
    chk("midrst_key", bus.core_key_o, 256'd0);
    rst = 1'b0;
    repeat (25) @(posedge clk); #1;
    chk("late_result_ignored", {bus.busy_o, bus.data_valid_o, bus.data_o}, 130'd0);
    chk("final_drained", exp_h.size() + exp_e.size() + exp_d.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end
endmodule
